// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: source request/ready, FIFO write side and debug counters of the write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
);
    logic                     enable_i;
    logic [N_CH-1:0]          ch_mask_i;
    logic [N_CH-1:0]          req_valid_i;
    logic [N_CH*DATA_W-1:0]   req_data_i;
    logic [N_CH-1:0]          req_ready_o;
    logic                     wr_en_o;
    logic [DATA_W-1:0]        wr_data_o;
    logic [N_CH-1:0]          grant_o;
    logic                     burst_done_o;
    logic [N_CH*CNT_W-1:0]    ch_count_o;

    modport slave (
        input  enable_i, ch_mask_i, req_valid_i, req_data_i,
        output req_ready_o, wr_en_o, wr_data_o, grant_o, burst_done_o, ch_count_o
    );

    modport master (
        output enable_i, ch_mask_i, req_valid_i, req_data_i,
        input  req_ready_o, wr_en_o, wr_data_o, grant_o, burst_done_o, ch_count_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst scheduler sharing one FIFO write port between N_CH sources.
module fifo_wr_arbiter #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 12,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic              rx_clk_i,
    input  logic              rst_i,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int PW = $clog2(N_CH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             r_state;
    logic [N_CH-1:0]    r_grant;
    logic [PW-1:0]      r_gidx;
    logic [PW-1:0]      r_ptr;
    logic [BW-1:0]      r_beat;
    logic               r_wr_en;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt [N_CH];

    logic [N_CH-1:0]    w_elig;
    logic               w_found;
    logic [PW-1:0]      w_sel;
    logic               w_valid_g;
    logic               w_acc;
    logic               w_last;

    assign w_elig    = bus.req_valid_i & bus.ch_mask_i & {N_CH{bus.enable_i}};
    assign w_valid_g = bus.req_valid_i[r_gidx];
    assign w_acc     = (r_state == BURST) && w_valid_g;
    assign w_last    = r_beat == BW'(BURST_LEN - 1);

    // Scan downward so the closest channel after the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = N_CH; i >= 1; i--) begin
            if (w_elig[(int'(r_ptr) + i) % N_CH]) begin
                w_found = 1'b1;
                w_sel   = PW'((int'(r_ptr) + i) % N_CH);
            end
        end
    end

    always_ff @(posedge rx_clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_ptr     <= PW'(N_CH - 1);
            r_beat    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            for (int k = 0; k < N_CH; k++) r_cnt[k] <= '0;
        end else begin
            r_wr_en <= w_acc;
            r_done  <= 1'b0;
            if (w_acc) r_wr_data <= bus.req_data_i[r_gidx*DATA_W +: DATA_W];
            if (r_state == IDLE) begin
                if (w_found) begin
                    r_grant <= N_CH'(1) << w_sel;
                    r_gidx  <= w_sel;
                    r_ptr   <= w_sel;
                    r_beat  <= '0;
                    r_state <= BURST;
                end
            end else begin
                if (w_acc) begin
                    r_cnt[r_gidx] <= r_cnt[r_gidx] + CNT_W'(1);
                    r_beat        <= r_beat + BW'(1);
                end
                if (!w_valid_g || w_last) begin
                    r_done  <= 1'b1;
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            end
        end
    end

    assign bus.req_ready_o  = (r_state == BURST) ? r_grant : '0;
    assign bus.wr_en_o      = r_wr_en;
    assign bus.wr_data_o    = r_wr_data;
    assign bus.grant_o      = r_grant;
    assign bus.burst_done_o = r_done;

    for (genvar k = 0; k < N_CH; k++) begin : g_cnt
        assign bus.ch_count_o[k*CNT_W +: CNT_W] = r_cnt[k];
    end
endmodule
